// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, receive FSM encoding and the
// parity helper used by both the transmit and receive sides.
package uart_pkg;

  // Frame layout: start(0), DATA_BITS data bits LSB first, parity, stop(1).
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Receive FSM encoding, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // One stored receive entry; parity_err sits above the data byte.
  typedef struct packed {
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  // Parity bit the transmitter sends for a byte: even (^data) or odd (~^data).
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read port and registered full/empty.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the push is dropped and flagged on o_drop. A pop from an
// empty FIFO is still acknowledged and returns zero so a bus read never stalls.
module uart_sync_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_rd_ack,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count_next,
  output logic             o_drop
);

  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_rd_ack;
  logic [WIDTH-1:0] r_dout;

  logic w_pop_ok;
  logic w_push_ok;

  // A pop only consumes data when something is stored; a push into a full
  // FIFO needs the slot freed by a same-cycle pop.
  assign w_pop_ok  = i_pop && !r_empty;
  assign w_push_ok = i_push && (!r_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;

  // Occupancy after this edge; also feeds the receiver's flow control.
  always_comb begin
    o_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      o_count_next = r_count + C_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      o_count_next = r_count - C_ONE;
    end
  end

  // Storage array: write only, no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Registered read port; an empty read returns zero, otherwise data holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (w_pop_ok) begin
      r_dout <= r_mem[r_rd_ptr];
    end else if (i_pop) begin
      r_dout <= '0;
    end
  end

  // Pointers wrap naturally; count and flags are registered from next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_rd_ack <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end
      r_count  <= o_count_next;
      r_empty  <= (o_count_next == '0);
      r_full   <= (o_count_next == C_DEPTH);
      r_rd_ack <= i_pop;
    end
  end

  assign o_dout   = r_dout;
  assign o_rd_ack = r_rd_ack;
  assign o_empty  = r_empty;
  assign o_full   = r_full;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART serial-in/parallel-out receiver. One serial bit is sampled per
// baud_clk edge; good frames (stop bit 1) are stored with their parity-error
// tag, bad-stop frames raise a sticky frame error and are discarded.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int   FIFO_DEPTH_R = 16,
  parameter int   FIFO_WIDTH_R = 9,
  parameter logic PARITY_ODD   = 1'b0
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       rd_parity_err,
  output logic       PREADY_R,
  output logic       RxFE,
  output logic       RxFF,
  output logic       Rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int          AW          = $clog2(FIFO_DEPTH_R);
  localparam logic [AW:0] C_READY_MAX = (AW+1)'(FIFO_DEPTH_R - 2);
  localparam logic [AW:0] C_LAST_SLOT = (AW+1)'(FIFO_DEPTH_R - 1);
  localparam logic [2:0]  C_LAST_BIT  = 3'(DATA_BITS - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_rx_ready;

  logic                    w_in_stop;
  logic                    w_push;
  logic                    w_frame_bad;
  logic                    w_drop;
  logic [AW:0]             w_count_next;
  rx_entry_t               w_push_entry;
  logic [FIFO_WIDTH_R-1:0] w_dout;

  // Frame sequencing: wait for a start bit, collect data, then parity, then stop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (serial_in == START_BIT) w_state_next = DATA;
      DATA:    if (r_bit_cnt == C_LAST_BIT) w_state_next = PARITY;
      PARITY:  w_state_next = STOP;
      default: w_state_next = IDLE;
    endcase
  end

  // Shift data LSB first into its bit slot and latch the parity check result.
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: r_bit_cnt <= '0;
        DATA: begin
          r_shift[r_bit_cnt] <= serial_in;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
        end
        PARITY: r_parity_err <= serial_in ^ calc_parity(r_shift, PARITY_ODD);
        default: ;
      endcase
    end
  end

  // The stop bit decides the frame's fate in the same cycle it is sampled,
  // so the FSM is back in IDLE for a start bit on the very next edge.
  assign w_in_stop   = (r_state == STOP);
  assign w_push      = w_in_stop && (serial_in == STOP_BIT);
  assign w_frame_bad = w_in_stop && (serial_in != STOP_BIT);

  assign w_push_entry.parity_err = r_parity_err;
  assign w_push_entry.data       = r_shift;

  uart_sync_fifo #(
    .WIDTH (FIFO_WIDTH_R),
    .DEPTH (FIFO_DEPTH_R)
  ) u_fifo (
    .clk          (baud_clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_din        (w_push_entry),
    .i_pop        (rd_en),
    .o_dout       (w_dout),
    .o_rd_ack     (PREADY_R),
    .o_empty      (RxFE),
    .o_full       (RxFF),
    .o_count_next (w_count_next),
    .o_drop       (w_drop)
  );

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clr_err) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_bad) r_frame_err <= 1'b1;
      if (w_drop)      r_overrun   <= 1'b1;
    end
  end

  // Flow control: with one slot left, only advertise ready while no frame is
  // in flight, so the ready flag is down no later than the full flag rises.
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      r_rx_ready <= 1'b1;
    end else begin
      r_rx_ready <= (w_count_next <= C_READY_MAX) ||
                    ((w_count_next == C_LAST_SLOT) && (w_state_next == IDLE));
    end
  end

  assign data_out      = w_dout[DATA_BITS-1:0];
  assign rd_parity_err = w_dout[DATA_BITS];
  assign Rx_ready      = r_rx_ready;
  assign frame_err     = r_frame_err;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Scoreboard bench for uart_rx_sipo: every frame sent updates a queue of
// expected FIFO entries and error flags; every read pops and compares.
module tb_uart_rx_sipo;

  logic       baud_clk  = 1'b0;
  logic       rst       = 1'b0;
  logic       serial_in = 1'b1;
  logic       rd_en     = 1'b0;
  logic       clr_err   = 1'b0;
  logic [7:0] data_out;
  logic       rd_parity_err;
  logic       PREADY_R;
  logic       RxFE;
  logic       RxFF;
  logic       Rx_ready;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] sb[$];
  logic       exp_frame_err = 1'b0;
  logic       exp_overrun   = 1'b0;

  uart_rx_sipo #(
    .FIFO_DEPTH_R (16),
    .FIFO_WIDTH_R (9),
    .PARITY_ODD   (1'b0)
  ) dut (
    .baud_clk      (baud_clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .rd_en         (rd_en),
    .clr_err       (clr_err),
    .data_out      (data_out),
    .rd_parity_err (rd_parity_err),
    .PREADY_R      (PREADY_R),
    .RxFE          (RxFE),
    .RxFF          (RxFF),
    .Rx_ready      (Rx_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge baud_clk);
      serial_in = 1'b1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".data_out"},  32'(data_out),      32'h00);
    check_eq({tag, ".perr"},      32'(rd_parity_err), 32'd0);
    check_eq({tag, ".PREADY"},    32'(PREADY_R),      32'd0);
    check_eq({tag, ".RxFE"},      32'(RxFE),          32'd1);
    check_eq({tag, ".RxFF"},      32'(RxFF),          32'd0);
    check_eq({tag, ".Rx_ready"},  32'(Rx_ready),      32'd1);
    check_eq({tag, ".frame_err"}, 32'(frame_err),     32'd0);
    check_eq({tag, ".overrun"},   32'(overrun),       32'd0);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".RxFE"},      32'(RxFE),      32'(sb.size() == 0));
    check_eq({tag, ".RxFF"},      32'(RxFF),      32'(sb.size() == 16));
    check_eq({tag, ".frame_err"}, 32'(frame_err), 32'(exp_frame_err));
    check_eq({tag, ".overrun"},   32'(overrun),   32'(exp_overrun));
  endtask

  task automatic clear_errors();
    @(negedge baud_clk);
    clr_err = 1'b1;
    @(negedge baud_clk);
    clr_err       = 1'b0;
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
  endtask

  // Sends one frame with no trailing idle; optionally raises rd_en together
  // with the stop bit so the push and pop land on the same edge.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop, input logic rd_at_stop);
    logic [10:0] bits;
    logic [8:0]  rd_exp;
    bits = {stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge baud_clk);
      serial_in = bits[i];
      if (i == 10) rd_en = rd_at_stop;
    end
    rd_exp = 9'd0;
    if (rd_at_stop && sb.size() > 0) rd_exp = sb.pop_front();
    if (stop) begin
      if (sb.size() < 16) sb.push_back({bad_par, d});
      else exp_overrun = 1'b1;
    end else begin
      exp_frame_err = 1'b1;
    end
    $display("frame data=0x%02h bad_par=%0d stop=%0d rd=%0d queued=%0d",
             d, bad_par, stop, rd_at_stop, sb.size());
    if (rd_at_stop) begin
      @(negedge baud_clk);
      rd_en     = 1'b0;
      serial_in = 1'b1;
      check_eq("stop_rd.PREADY", 32'(PREADY_R),      32'd1);
      check_eq("stop_rd.data",   32'(data_out),      32'(rd_exp[7:0]));
      check_eq("stop_rd.perr",   32'(rd_parity_err), 32'(rd_exp[8]));
    end
  endtask

  task automatic do_read(input string tag);
    logic [8:0] e;
    @(negedge baud_clk);
    rd_en = 1'b1;
    e = 9'd0;
    if (sb.size() > 0) e = sb.pop_front();
    @(negedge baud_clk);
    rd_en = 1'b0;
    $display("read %s data_out=0x%02h perr=%0d want=0x%02h/%0d",
             tag, data_out, rd_parity_err, e[7:0], e[8]);
    check_eq({tag, ".PREADY"}, 32'(PREADY_R),      32'd1);
    check_eq({tag, ".data"},   32'(data_out),      32'(e[7:0]));
    check_eq({tag, ".perr"},   32'(rd_parity_err), 32'(e[8]));
    @(negedge baud_clk);
    check_eq({tag, ".PREADY_low"}, 32'(PREADY_R), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge baud_clk);
    check_reset_vals("reset");
    rst = 1'b1;
    idle(2);

    // Single good frame
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("a5");
    do_read("a5");
    check_status("a5_read");

    // Parity error is stored and tagged
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    idle(1);
    check_status("3c");
    do_read("3c");

    // Bad stop bit: nothing stored, sticky frame error, then cleared
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_status("55_badstop");
    clear_errors();
    check_status("55_cleared");
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("01");
    do_read("01");

    // Fill with back-to-back frames, then overrun
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("fill16");
    check_eq("fill16.Rx_ready", 32'(Rx_ready), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("overrun");
    for (int i = 0; i < 16; i++) do_read("drain1");
    check_status("drain1_done");
    check_eq("drain1.Rx_ready", 32'(Rx_ready), 32'd1);
    clear_errors();
    check_status("ovr_cleared");

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("refill16");
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    idle(1);
    check_status("push_pop_full");
    for (int i = 0; i < 16; i++) do_read("drain2");
    check_status("drain2_done");

    // Read from empty
    do_read("empty");

    // Reset in the middle of a frame
    send_frame(8'h42, 1'b0, 1'b1, 1'b0);
    idle(1);
    do_read("pre_rst");
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h24, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("pre_rst");
    @(negedge baud_clk);
    serial_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge baud_clk);
      serial_in = i[0];
    end
    @(negedge baud_clk);
    rst = 1'b0;
    #1;
    check_reset_vals("mid_frame_rst");
    sb.delete();
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
    @(negedge baud_clk);
    rst       = 1'b1;
    serial_in = 1'b1;
    idle(2);
    check_status("post_rst");
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle(1);
    check_status("81");
    do_read("81");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
